// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M-style multiply/divide unit for the EX stage.
//
// Handles MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU for any even XLEN
// from 8 to 64. It accepts one operation at a time and stalls the pipeline
// through busy_o. The result is returned with a single-cycle valid_o pulse.
//
// Ports:
//   clk       CPU clock, rising-edge
//   rst_n     asynchronous active-low reset
//   start_i   request, sampled only when idle or in the result cycle
//   op_i      funct3 operation select
//   a_i/b_i   rs1/rs2 operands
//   flush_i   abort any in-flight operation
//   busy_o    stall request (high while computing)
//   valid_o   one-cycle result strobe
//   result_o  result, held until the next accepted start
module muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned W2 = 2 * XLEN;

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   dvsr_q, dvsr_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand decode for the incoming request.
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            fast_zero, fast_ovf, accept;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op_i)
      3'd1, 3'd4, 3'd6: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      3'd2:    a_signed = 1'b1;
      default: ;
    endcase
  end

  assign a_neg = a_signed & a_i[XLEN-1];
  assign b_neg = b_signed & b_i[XLEN-1];
  assign a_mag = a_neg ? (~a_i + XLEN'(1)) : a_i;
  assign b_mag = b_neg ? (~b_i + XLEN'(1)) : b_i;

  assign fast_zero = op_i[2] && (b_i == '0);
  // Only DIV/REM (op[0]==0) can overflow: most-negative / -1.
  assign fast_ovf  = op_i[2] && !op_i[0] && (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (&b_i);

  assign accept = start_i && !flush_i && ((state_q == StIdle) || (state_q == StDone));

  // One iteration of each datapath.
  logic [XLEN:0]   mul_sum, rem_sh, div_diff;
  logic [W2-1:0]   mul_next, div_next;

  assign mul_sum  = {1'b0, acc_q[W2-1:XLEN]} + {1'b0, dvsr_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[W2-1:1]};

  // Partial remainder stays below the divisor, so XLEN+1 bits hold the shift.
  assign rem_sh   = acc_q[W2-1:XLEN-1];
  assign div_diff = rem_sh - {1'b0, dvsr_q};
  assign div_next = div_diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  // Sign fix-up and result selection.
  logic [W2-1:0]   prod_fix;
  logic [XLEN-1:0] quot_fix, rem_fix, fix_res;

  assign prod_fix = neg_q ? (~acc_q + W2'(1)) : acc_q;
  assign quot_fix = neg_q ? (~acc_q[XLEN-1:0] + XLEN'(1)) : acc_q[XLEN-1:0];
  assign rem_fix  = neg_q ? (~acc_q[W2-1:XLEN] + XLEN'(1)) : acc_q[W2-1:XLEN];

  always_comb begin
    fix_res = '0;
    case (op_q)
      3'd0:             fix_res = acc_q[XLEN-1:0];
      3'd1, 3'd2, 3'd3: fix_res = prod_fix[W2-1:XLEN];
      3'd4, 3'd5:       fix_res = quot_fix;
      default:          fix_res = rem_fix;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    dvsr_d   = dvsr_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    result_d = result_q;

    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          op_d   = op_i;
          dvsr_d = b_mag;
          cnt_d  = '0;
          if (fast_zero) begin
            acc_d   = {a_i, {XLEN{1'b1}}};
            neg_d   = 1'b0;
            state_d = StFix;
          end else if (fast_ovf) begin
            acc_d   = {{XLEN{1'b0}}, a_i};
            neg_d   = 1'b0;
            state_d = StFix;
          end else begin
            acc_d   = {{XLEN{1'b0}}, a_mag};
            state_d = StRun;
            case (op_i)
              3'd1, 3'd4: neg_d = a_neg ^ b_neg;
              3'd2, 3'd6: neg_d = a_neg;
              default:    neg_d = 1'b0;
            endcase
          end
        end
      end
      StRun: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        result_d = fix_res;
        valid_d  = 1'b1;
        state_d  = StDone;
      end
      default: state_d = StIdle;
    endcase

    // Flush wins over everything except reset; the last result is kept.
    if (flush_i) begin
      state_d  = StIdle;
      valid_d  = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= '0;
      neg_q    <= 1'b0;
      dvsr_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      dvsr_q   <= dvsr_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q == StRun) || (state_q == StFix);
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): directed vectors with
// literal expectations plus a cycle-level behavioural model compared at
// every falling edge.
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            flush_i;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  int n_pass  = 0;
  int n_total = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Arithmetic reference, straight from the RV32M definitions.
  function automatic logic [31:0] model_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ub, ua;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ia = a;
    ib = b;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic is_fast(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    return op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Timing model: accepted request completes after a fixed number of edges.
  logic        m_busy, m_valid;
  logic [31:0] m_res, m_pend;
  int          m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_res   <= '0;
      m_pend  <= '0;
      m_left  <= 0;
    end else if (flush_i) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_left  <= 0;
    end else if (!m_busy && start_i) begin
      m_pend  <= model_res(op_i, a_i, b_i);
      m_left  <= is_fast(op_i, a_i, b_i) ? 1 : XLEN + 1;
      m_busy  <= 1'b1;
      m_valid <= 1'b0;
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b1;
        m_res   <= m_pend;
      end else begin
        m_valid <= 1'b0;
      end
      m_left <= m_left - 1;
    end else begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    check_val("cyc busy", {63'b0, busy_o}, {63'b0, m_busy});
    check_val("cyc valid", {63'b0, valid_o}, {63'b0, m_valid});
    check_val("cyc result", {32'b0, result_o}, {32'b0, m_res});
  end

  // Issue a request now; returns #1 after the edge on which valid_o rose.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int n;
    check_val({name, " model"}, {32'b0, model_res(op, a, b)}, {32'b0, exp});
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    n = 0;
    while (!valid_o && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val({name, " result"}, {32'b0, result_o}, {32'b0, exp});
    check_val({name, " latency"}, 64'(n), 64'(exp_lat));
  endtask

  task automatic gap();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int seen;
    logic [31:0] held;

    rst_n   = 1'b0;
    start_i = 1'b0;
    op_i    = '0;
    a_i     = '0;
    b_i     = '0;
    flush_i = 1'b0;
    #1;
    check_val("reset busy", {63'b0, busy_o}, 64'd0);
    check_val("reset valid", {63'b0, valid_o}, 64'd0);
    check_val("reset result", {32'b0, result_o}, 64'd0);
    #21;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("MUL", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);            gap();
    run_op("MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);  gap();
    run_op("MULH", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);   gap();
    run_op("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33); gap();
    run_op("DIV", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);            gap();
    run_op("REM", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);            gap();
    run_op("DIVU", 3'd5, 32'd100, 32'd7, 32'd14, 33);                         gap();
    run_op("REMU", 3'd7, 32'd100, 32'd7, 32'd2, 33);                          gap();
    run_op("DIVU0", 3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1);                 gap();
    run_op("REM0", 3'd6, 32'h1234, 32'd0, 32'h1234, 1);                       gap();
    run_op("DIVOVF", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);   gap();
    run_op("REMOVF", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);           gap();
    run_op("MULHneg", 3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 33);        gap();
    run_op("REMneg", 3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);                  gap();

    // Back-to-back: second start issued in the DONE cycle.
    run_op("B2B first", 3'd0, 32'd3, 32'd5, 32'd15, 33);
    run_op("B2B second", 3'd5, 32'd100, 32'd7, 32'd14, 33);
    gap();

    // start_i held through RUN with changing operands is ignored.
    start_i = 1'b1;
    op_i    = 3'd0;
    a_i     = 32'd11;
    b_i     = 32'd13;
    @(posedge clk);
    #1;
    a_i = 32'd99;
    b_i = 32'd99;
    n = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      n++;
    end
    start_i = 1'b0;
    while (!valid_o && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("hold result", {32'b0, result_o}, 64'd143);
    check_val("hold latency", 64'(n), 64'd33);
    gap();

    // Flush mid-RUN.
    held    = result_o;
    start_i = 1'b1;
    op_i    = 3'd3;
    a_i     = 32'h1234_5678;
    b_i     = 32'h9ABC_DEF0;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    check_val("flush busy", {63'b0, busy_o}, 64'd0);
    check_val("flush valid", {63'b0, valid_o}, 64'd0);
    check_val("flush result", {32'b0, result_o}, {32'b0, held});
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (valid_o) seen++;
    end
    check_val("flush no valid", 64'(seen), 64'd0);

    // Start together with flush is dropped.
    start_i = 1'b1;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    flush_i = 1'b0;
    check_val("flush+start busy", {63'b0, busy_o}, 64'd0);
    gap();

    // Asynchronous reset mid-RUN.
    start_i = 1'b1;
    op_i    = 3'd5;
    a_i     = 32'd1000;
    b_i     = 32'd3;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("arst busy", {63'b0, busy_o}, 64'd0);
    check_val("arst valid", {63'b0, valid_o}, 64'd0);
    check_val("arst result", {32'b0, result_o}, 64'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("after reset", 3'd7, 32'd1000, 32'd3, 32'd1, 33);
    gap();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
